seq_det_param: RTL and testbench
================================

// Module: seq_det_param
// PURPOSE
//  Parametrised serial sequence detector, successor to the fixed 4-bit Mealy detectors.
//  The target pattern (up to MAX_LEN bits) and its length are loaded at run time.
//  Overlap or non-overlap counting is selectable.
//  Provides a Mealy (same-cycle) flag, a registered flag and a saturating match counter.
//  Sits after a serial bit source (UART RX / line decoder) as a framing/marker detector.
// PARAMETERS
//  MAX_LEN   16  max pattern length in bits (2..32)
//  CNT_W     8   match counter width
//  LEN_W     5   width of cfg_len, >= clog2(MAX_LEN+1)
// PORTS
//  clk       in   1        rising-edge clock; single clock domain
//  rst       in   1        asynchronous, active-low reset
//  i         in   1        serial data bit
//  i_vld     in   1        i is sampled only when high
//  cfg_ld    in   1        load pattern/length/mode this cycle
//  cfg_pat   in   MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last
//  cfg_len   in   LEN_W    pattern length, 2..MAX_LEN
//  cfg_ovl   in   1        1 = overlapping detection, 0 = non-overlapping
//  cnt_clr   in   1        synchronous clear of match counter
//  q         out  1        Mealy match: comb, high in the cycle the last pattern bit is accepted
//  q_r       out  1        q registered (Moore-style, 1 cycle latency)
//  match_cnt out  CNT_W    number of matches, saturates at all-ones
//  cfg_err   out  1        sticky: last cfg_len loaded was outside 2..MAX_LEN
// BEHAVIOUR
//  Reset (rst=0, async): history=0, fill=0, pat=0, len=2, ovl=1, q_r=0, match_cnt=0, cfg_err=0.
//  With reset asserted and pat=0, q=0 because fill=0.
//  State
//   - hist[MAX_LEN-1:0]: shift register; on an accepted bit, hist <= {hist[MAX_LEN-2:0], i}.
//   - fill: saturating count of accepted bits, 0..MAX_LEN, since reset/cfg_ld/non-overlap match.
//  Match (comb)
//   - q = i_vld & ~cfg_ld & (fill+1 >= len) & ({hist,i} masked to low len bits == pat masked to len).
//  On an accepted bit (i_vld=1, cfg_ld=0)
//   - Shift hist.
//   - If q & ~ovl: fill <= 0, so the next match needs len fresh bits.
//   - Otherwise fill <= min(fill+1, MAX_LEN).
//  i_vld=0: no state change; q=0.
//  q_r <= q every cycle.
//  match_cnt: cnt_clr has priority -> 0. Else if q & (match_cnt != all-ones), +1. Holds at all-ones.
//  cnt_clr together with q: result is 0 (the match is dropped).
//  cfg_ld
//   - Latches pat, len, ovl; clears hist and fill.
//   - The i bit in that cycle is discarded; q=0 that cycle. match_cnt is unaffected.
//  Illegal cfg_len (<2 or >MAX_LEN): len clamps to 2 or MAX_LEN respectively; cfg_err <= 1.
//  cfg_err is cleared only by reset or a legal cfg_ld.
//  Pattern bits above len-1 are ignored (masked) in the compare.
//  Reset mid-stream: all state returns to reset values immediately, irrespective of clk.
// STRUCTURE
//  Shared package seq_det_pkg
//   - localparams: MAX_LEN, LEN_W, default len/ovl.
//   - function len_mask(len) returning a MAX_LEN-bit mask.
//  Sub-module sat_counter #(W)
//   - inc, clr, cnt outputs; saturating; clr priority.
//   - Instantiated once for match_cnt.
//  Top holds the config regs, the hist/fill registers and the masked comparator.
// TESTING
//  1. Load pat=4'b1100, len=4, ovl=1; stream 1,1,0,0,1,1,0,0
//     -> q high on bits 4 and 8; q_r one cycle later; match_cnt=2.
//  2. pat=4'b1010, len=4, ovl=1; stream 1,0,1,0,1,0
//     -> q on bits 4 and 6, cnt=2. Same stream with ovl=0 -> q on bit 4 only, cnt=1.
//  3. Stream 1,1,0 with i_vld=0 gaps between bits, then 0
//     -> match on the 4th valid bit only; q=0 during the gaps.
//  4. cfg_ld in the cycle a completing bit arrives -> q=0, fill=0; cfg_len=1 -> len=2, cfg_err=1.
//  5. CNT_W=2: 5 matches -> match_cnt saturates at 3. cnt_clr coincident with q -> 0.
//  6. Assert rst between clock edges mid-pattern -> q_r/match_cnt=0 at once; old prefix does not complete a match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int   MAX_LEN_DEF = 16;
  localparam int   LEN_W_DEF   = 5;
  localparam int   DEF_LEN     = 2;
  localparam logic DEF_OVL     = 1'b1;

  // Mask with the low `len` bits set; callers truncate to their own width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [32:0] m;
    m = (33'd1 << len) - 33'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear first, then count up until all-ones and hold there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/seq_det_param.sv
// Run-time configurable serial pattern detector with overlap/non-overlap
// matching, a same-cycle match flag, a registered flag and a match counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i,
  input  logic               i_vld,
  input  logic               cfg_ld,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               q,
  output logic               q_r,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist, pat, mask, cur;
  logic [LEN_W-1:0]   len, fill, len_nxt;
  logic [LEN_W:0]     fill_p1;
  logic               ovl, accept, len_bad;

  // A bit is only taken when valid and no reconfiguration is happening.
  assign accept  = i_vld & ~cfg_ld;
  assign cur     = {hist[MAX_LEN-2:0], i};
  assign mask    = MAX_LEN'(len_mask(32'(len)));
  assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
  // fill gate stops stale/cleared history bits from forming a false match.
  assign q       = accept & (fill_p1 >= {1'b0, len}) & (((cur ^ pat) & mask) == '0);

  // Clamp an out-of-range length into 2..MAX_LEN and flag it.
  always_comb begin
    len_nxt = cfg_len;
    len_bad = 1'b0;
    if (cfg_len < LEN_W'(2)) begin
      len_nxt = LEN_W'(2);
      len_bad = 1'b1;
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_nxt = LEN_W'(MAX_LEN);
      len_bad = 1'b1;
    end
  end

  // Configuration registers; cfg_err tracks the most recent load only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat     <= '0;
      len     <= LEN_W'(DEF_LEN);
      ovl     <= DEF_OVL;
      cfg_err <= 1'b0;
    end else if (cfg_ld) begin
      pat     <= cfg_pat;
      len     <= len_nxt;
      ovl     <= cfg_ovl;
      cfg_err <= len_bad;
    end
  end

  // History shift register and fill count; non-overlap match restarts fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (cfg_ld) begin
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= cur;
      if (q && !ovl)                     fill <= '0;
      else if (fill != LEN_W'(MAX_LEN))  fill <= fill + LEN_W'(1);
    end
  end

  // Registered copy of the match flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_r <= 1'b0;
    else      q_r <= q;
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (q),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench: the driver pushes expected outputs from a bit-queue
// reference model; a negedge monitor pops and compares.
module tb_seq_det_param;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 0, rst = 0, i = 0, i_vld = 0, cfg_ld = 0, cfg_ovl = 0, cnt_clr = 0;
  logic [MAX_LEN-1:0] cfg_pat = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               q, q_r, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  seq_det_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i(i), .i_vld(i_vld), .cfg_ld(cfg_ld),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .q(q), .q_r(q_r), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             q;
    logic             q_r;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;

  // reference model: accepted bits since reset/load/non-overlap match
  bit                 acc[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len, m_cnt;
  bit                 m_ovl, m_err, m_qprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    acc.delete();
    m_pat = '0; m_len = 2; m_ovl = 1; m_cnt = 0; m_err = 0; m_qprev = 0;
  endtask

  task automatic m_step(input bit bi, input bit bv, input bit bl,
                        input logic [MAX_LEN-1:0] bp, input int bln, input bit bo, input bit bc);
    bit hit, b;
    hit = 0;
    if (bv && !bl && acc.size() + 1 >= m_len) begin
      hit = 1;
      // window of the last m_len bits, oldest first, against pat[len-1..0]
      for (int j = 0; j < m_len; j++) begin
        b = (j == m_len - 1) ? bi : acc[acc.size() - (m_len - 1) + j];
        if (b != m_pat[m_len - 1 - j]) hit = 0;
      end
    end
    sb.push_back('{hit, m_qprev, CNT_W'(m_cnt), m_err});
    if (bl) begin
      acc.delete();
      m_pat = bp; m_ovl = bo;
      if (bln < 2)            begin m_len = 2;       m_err = 1; end
      else if (bln > MAX_LEN) begin m_len = MAX_LEN; m_err = 1; end
      else                    begin m_len = bln;     m_err = 0; end
    end else if (bv) begin
      if (hit && !m_ovl) acc.delete();
      else begin
        acc.push_back(bi);
        if (acc.size() > MAX_LEN) void'(acc.pop_front());
      end
    end
    if (bc) m_cnt = 0;
    else if (hit && m_cnt != CNT_MAX) m_cnt++;
    m_qprev = hit;
  endtask

  // one clock: drive inputs, record expectation, advance past the edge
  task automatic cyc(input bit bi, input bit bv, input bit bl = 0,
                     input logic [MAX_LEN-1:0] bp = '0, input int bln = 0,
                     input bit bo = 0, input bit bc = 0);
    i = bi; i_vld = bv; cfg_ld = bl; cfg_pat = bp; cfg_len = LEN_W'(bln);
    cfg_ovl = bo; cnt_clr = bc;
    m_step(bi, bv, bl, bp, bln, bo, bc);
    @(posedge clk); #1;
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int k = n - 1; k >= 0; k--) cyc(v[k], 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst && sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("q",         32'(q),         32'(mon_e.q));
      check("q_r",       32'(q_r),       32'(mon_e.q_r));
      check("match_cnt", 32'(match_cnt), 32'(mon_e.cnt));
      check("cfg_err",   32'(cfg_err),   32'(mon_e.err));
    end
  end

  initial begin
    m_reset();
    #12;
    check("rst_q",   32'(q),         0);
    check("rst_q_r", 32'(q_r),       0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_err", 32'(cfg_err),   0);
    @(posedge clk); #1; rst = 1;

    // T1: 1100 overlap
    cyc(0, 0, 1, 16'b1100, 4, 1);
    stream(32'b11001100, 8);
    cyc(0, 0);
    check("t1_cnt", 32'(match_cnt), 2);
    cyc(0, 0, 0, '0, 0, 0, 1);

    // T2: 1010 overlap then non-overlap
    cyc(0, 0, 1, 16'b1010, 4, 1);
    stream(32'b101010, 6);
    cyc(0, 0);
    check("t2_ovl_cnt", 32'(match_cnt), 2);
    cyc(0, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 16'b1010, 4, 0);
    stream(32'b101010, 6);
    cyc(0, 0);
    check("t2_novl_cnt", 32'(match_cnt), 1);
    cyc(0, 0, 0, '0, 0, 0, 1);

    // T3: gaps between valid bits
    cyc(0, 0, 1, 16'b1100, 4, 1);
    cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(0, 0); cyc(0, 1); cyc(1, 0); cyc(0, 1);
    cyc(0, 0);
    check("t3_cnt", 32'(match_cnt), 1);

    // T4: load on completing bit, illegal lengths
    stream(32'b110, 3);
    cyc(0, 1, 1, 16'b1100, 4, 1);
    stream(32'b0, 1);
    cyc(0, 0, 1, 16'hFFFF, 1, 1);
    check("t4_err_lo", 32'(cfg_err), 1);
    stream(32'b11, 2);
    cyc(0, 0, 1, 16'hFFFF, 20, 0);
    check("t4_err_hi", 32'(cfg_err), 1);
    stream(32'hFFFF, 16);
    cyc(0, 0, 1, 16'b0110, 3, 1);
    check("t4_err_clr", 32'(cfg_err), 0);
    stream(32'b01100110, 8);

    // T5: saturation at 3, clear coincident with a match
    cyc(0, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 16'b01, 2, 1);
    stream(32'b0101010101, 10);
    cyc(0, 0);
    check("t5_sat", 32'(match_cnt), 3);
    cyc(0, 1);
    cyc(1, 1, 0, '0, 0, 0, 1);
    cyc(0, 0);
    check("t5_clr_hit", 32'(match_cnt), 0);

    // T6: async reset mid-cycle
    cyc(0, 0, 1, 16'b1100, 4, 1);
    stream(32'b1100, 4);
    i_vld = 0; cfg_ld = 0; cnt_clr = 0;
    check("t6_pre_qr", 32'(q_r), 1);
    @(negedge clk); #2;
    rst = 0; #1;
    check("t6_qr",  32'(q_r),       0);
    check("t6_cnt", 32'(match_cnt), 0);
    @(posedge clk); #1;
    check("t6_hold_cnt", 32'(match_cnt), 0);
    rst = 1;
    m_reset();
    stream(32'b00, 2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r, ln;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(2, 5);
        cyc(1'($urandom), 1'($urandom), 1, MAX_LEN'($urandom), ln, 1'($urandom));
      end else begin
        cyc(1'($urandom), $urandom_range(0, 9) < 7, 0, '0, 0, 0, $urandom_range(0, 49) == 0);
      end
    end
    cyc(0, 0);
    @(negedge clk); #1;
    check("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
